// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, RX/TX state encodings and baud divider helpers shared by the UART.
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

    function automatic int calc_div(input int freq, input int baud, input int os);
        longint f, b;
        f = longint'(freq);
        b = longint'(baud) * longint'(os);
        return int'((f + b / 2) / b);
    endfunction

    // Actual baud must sit within 2% of the requested one.
    function automatic bit baud_ok(input int freq, input int baud, input int os);
        longint b, err;
        b = longint'(baud) * longint'(os) * longint'(calc_div(freq, baud, os));
        err = longint'(freq) - b;
        err = err < 0 ? -err : err;
        return calc_div(freq, baud, os) >= 1 && err * 50 <= b;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; simultaneous push and pop are both honoured even when full.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic w_push, w_pop;
    assign o_empty = r_wr == r_rd;
    assign o_full = r_wr == {~r_rd[AW], r_rd[AW-1:0]};
    assign w_pop = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + (AW+1)'(w_push);
            r_rd <= r_rd + (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/uart_cfg.sv
// uart_cfg: parametrised UART transceiver with tick-enable baud timing and an RX FIFO carrying per-word error flags.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int FREQ       = 1_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int RX_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_frame_err_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_overrun_o,
    output logic                 tx_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_busy_o
);
    localparam int DIV = calc_div(FREQ, BAUD, OVERSAMPLE);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] SMP_A = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] SMP_C = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (!baud_ok(FREQ, BAUD, OVERSAMPLE) || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 ||
        RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_cfg: illegal parameter set");
    end

    logic [1:0] r_sync;
    rx_state_e r_rx_state, w_rx_next;
    logic [DW-1:0] r_rx_div;
    logic [OW-1:0] r_rx_os;
    logic [BW-1:0] r_rx_bit;
    logic [1:0] r_rx_smp;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic r_rx_perr;
    logic w_rxs, w_rx_tick, w_rx_smp, w_rx_vote, w_rx_maj, w_rx_end, w_rx_push;
    logic w_fifo_empty, w_fifo_full;
    logic [DATA_BITS+1:0] w_fifo_out;

    assign w_rxs = r_sync[1];
    assign w_rx_tick = r_rx_div == DIV_LAST;
    assign w_rx_smp = w_rx_tick && r_rx_os >= SMP_A && r_rx_os <= SMP_C;
    assign w_rx_vote = w_rx_tick && r_rx_os == SMP_C;
    assign w_rx_maj = (r_rx_smp[1] & r_rx_smp[0]) | (r_rx_smp[1] & w_rxs) | (r_rx_smp[0] & w_rxs);
    assign w_rx_end = w_rx_tick && r_rx_os == OS_LAST;

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE:   w_rx_next = w_rxs ? RX_IDLE : RX_START;
            RX_START:  w_rx_next = (w_rx_vote && w_rx_maj) ? RX_IDLE : w_rx_end ? RX_DATA : RX_START;
            RX_DATA:   if (w_rx_end && r_rx_bit == BIT_LAST) w_rx_next = PARITY != PARITY_NONE ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_end) w_rx_next = RX_STOP;
            RX_STOP: if (w_rx_vote) begin
                w_rx_push = 1'b1;
                w_rx_next = w_rx_maj ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK:  if (w_rxs) w_rx_next = RX_IDLE;
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    // Bit timing restarts on the cycle the start edge is seen, so counters are held clear in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_div <= '0;
            r_rx_os <= '0;
            r_rx_bit <= '0;
            r_rx_smp <= '0;
            r_rx_shift <= '0;
            r_rx_perr <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx_i};
            r_rx_state <= w_rx_next;
            r_rx_div <= (r_rx_state == RX_IDLE || w_rx_tick) ? '0 : r_rx_div + 1'b1;
            r_rx_os <= (r_rx_state == RX_IDLE || w_rx_end) ? '0 : r_rx_os + OW'(w_rx_tick);
            r_rx_bit <= r_rx_state != RX_DATA ? '0 : r_rx_bit + BW'(w_rx_end);
            if (w_rx_smp) r_rx_smp <= {r_rx_smp[0], w_rxs};
            if (r_rx_state == RX_DATA && w_rx_vote) r_rx_shift <= {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_state == RX_IDLE) r_rx_perr <= 1'b0;
            else if (r_rx_state == RX_PARITY && w_rx_vote) r_rx_perr <= ^r_rx_shift ^ w_rx_maj ^ (PARITY == PARITY_ODD);
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_rx_push),
        .i_data  ({r_rx_shift, ~w_rx_maj, r_rx_perr}),
        .i_pop   (rx_ready_i),
        .o_data  (w_fifo_out),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign {rx_data_o, rx_frame_err_o, rx_parity_err_o} = w_fifo_out;
    assign rx_valid_o = !w_fifo_empty;
    assign rx_overrun_o = w_rx_push && w_fifo_full && !rx_ready_i;

    tx_state_e r_tx_state, w_tx_next;
    logic [DW-1:0] r_tx_div;
    logic [OW-1:0] r_tx_os;
    logic [BW-1:0] r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic r_tx_par, r_tx, w_tx_bit, w_tx_go, w_tx_tick, w_tx_end;

    assign w_tx_go = r_tx_state == TX_IDLE && tx_valid_i;
    assign w_tx_tick = r_tx_div == DIV_LAST;
    assign w_tx_end = w_tx_tick && r_tx_os == OS_LAST;

    // w_tx_bit is the line level for the next cycle; registering it keeps tx_o glitch-free.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_bit = r_tx;
        case (r_tx_state)
            TX_IDLE: if (tx_valid_i) begin
                w_tx_next = TX_START;
                w_tx_bit = 1'b0;
            end
            TX_START: if (w_tx_end) begin
                w_tx_next = TX_DATA;
                w_tx_bit = r_tx_shift[0];
            end
            TX_DATA: if (w_tx_end) begin
                w_tx_next = r_tx_bit != BIT_LAST ? TX_DATA : PARITY != PARITY_NONE ? TX_PARITY : TX_STOP;
                w_tx_bit = r_tx_bit != BIT_LAST ? r_tx_shift[1] : PARITY != PARITY_NONE ? r_tx_par : 1'b1;
            end
            TX_PARITY: if (w_tx_end) begin
                w_tx_next = TX_STOP;
                w_tx_bit = 1'b1;
            end
            TX_STOP: if (w_tx_end && r_tx_bit == STOP_LAST) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx <= 1'b1;
            r_tx_div <= '0;
            r_tx_os <= '0;
            r_tx_bit <= '0;
            r_tx_shift <= '0;
            r_tx_par <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx <= w_tx_bit;
            r_tx_div <= (w_tx_go || w_tx_tick) ? '0 : r_tx_div + 1'b1;
            r_tx_os <= (w_tx_go || w_tx_end) ? '0 : r_tx_os + OW'(w_tx_tick);
            r_tx_bit <= w_tx_next != r_tx_state ? '0 : r_tx_bit + BW'(w_tx_end);
            if (w_tx_go) begin
                r_tx_shift <= tx_data_i;
                r_tx_par <= ^tx_data_i ^ (PARITY == PARITY_ODD);
            end else if (r_tx_state == TX_DATA && w_tx_end) begin
                r_tx_shift <= r_tx_shift >> 1;
            end
        end
    end

    assign tx_o = r_tx;
    assign tx_ready_o = r_tx_state == TX_IDLE;
    assign tx_busy_o = !tx_ready_o;
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: scoreboard bench for uart_cfg with an 8N1 and an 8E1 instance at 16 clk per bit.
module tb_uart_cfg;
    localparam int BIT_CLK = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_drv = 1'b1, sel_e = 1'b0, loop = 1'b0;
    logic rdy_n = 1'b1, rdy_e = 1'b1;
    logic [7:0] txd_n = '0, txd_e = '0;
    logic txv_n = 1'b0, txv_e = 1'b0;
    logic rx_n, rx_e;
    logic [7:0] rxd_n, rxd_e;
    logic val_n, val_e, fe_n, fe_e, pe_n, pe_e, ovr_n, ovr_e;
    logic tx_n, tx_e, trdy_n, trdy_e, busy_n, busy_e;

    word_t q_n[$], q_e[$];
    word_t m_n, m_e;
    int checks = 0, errors = 0, ovr_cnt = 0;

    always #5 clk = ~clk;

    assign rx_n = sel_e ? 1'b1 : rx_drv;
    assign rx_e = loop ? tx_e : sel_e ? rx_drv : 1'b1;

    uart_cfg #(.FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
               .OVERSAMPLE(16), .RX_DEPTH(4)) u_n (
        .clk(clk), .reset(reset), .rx_i(rx_n), .rx_data_o(rxd_n), .rx_valid_o(val_n), .rx_ready_i(rdy_n),
        .rx_frame_err_o(fe_n), .rx_parity_err_o(pe_n), .rx_overrun_o(ovr_n), .tx_o(tx_n),
        .tx_data_i(txd_n), .tx_valid_i(txv_n), .tx_ready_o(trdy_n), .tx_busy_o(busy_n)
    );

    uart_cfg #(.FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
               .OVERSAMPLE(16), .RX_DEPTH(4)) u_e (
        .clk(clk), .reset(reset), .rx_i(rx_e), .rx_data_o(rxd_e), .rx_valid_o(val_e), .rx_ready_i(rdy_e),
        .rx_frame_err_o(fe_e), .rx_parity_err_o(pe_e), .rx_overrun_o(ovr_e), .tx_o(tx_e),
        .tx_data_i(txd_e), .tx_valid_i(txv_e), .tx_ready_o(trdy_e), .tx_busy_o(busy_e)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a word leaves the RX FIFO.
    always @(negedge clk) begin
        if (ovr_n) ovr_cnt++;
        if (val_n && rdy_n) begin
            if (q_n.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_n unexpected word: got data 0x%0h fe %0b pe %0b, expected none", rxd_n, fe_n, pe_n);
            end else begin
                m_n = q_n.pop_front();
                chk("rx_n data", 32'(rxd_n), 32'(m_n.d));
                chk("rx_n frame_err", 32'(fe_n), 32'(m_n.fe));
                chk("rx_n parity_err", 32'(pe_n), 32'(m_n.pe));
            end
        end
        if (val_e && rdy_e) begin
            if (q_e.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_e unexpected word: got data 0x%0h fe %0b pe %0b, expected none", rxd_e, fe_e, pe_e);
            end else begin
                m_e = q_e.pop_front();
                chk("rx_e data", 32'(rxd_e), 32'(m_e.d));
                chk("rx_e frame_err", 32'(fe_e), 32'(m_e.fe));
                chk("rx_e parity_err", 32'(pe_e), 32'(m_e.pe));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [10:0] bits, input int nb);
        for (int b = 0; b < nb; b++) begin
            rx_drv = bits[b];
            cyc(BIT_CLK);
        end
    endtask

    task automatic wait_drain(input bit e);
        int n = 0;
        while ((e ? q_e.size() : q_n.size()) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(e ? "drain rx_e" : "drain rx_n", 32'(e ? q_e.size() : q_n.size()), 32'd0);
    endtask

    // Sends one word and checks every line cycle plus the ready-return latency.
    task automatic tx_frame(input bit e, input logic [7:0] d, input logic [10:0] bits, input int nb);
        int k = 0, first = 0;
        logic act;
        if (e) begin txd_e = d; txv_e = 1'b1; end
        else begin txd_n = d; txv_n = 1'b1; end
        @(posedge clk);
        #1;
        txv_e = 1'b0; txv_n = 1'b0; txd_e = '0; txd_n = '0;
        for (int b = 0; b < nb; b++) begin
            act = bits[b];
            for (int j = 0; j < BIT_CLK; j++) begin
                @(negedge clk);
                k++;
                if ((e ? tx_e : tx_n) !== bits[b]) act = e ? tx_e : tx_n;
                if ((e ? trdy_e : trdy_n) && first == 0) first = k;
            end
            chk($sformatf("tx_%s bit %0d", e ? "e" : "n", b), 32'(act), 32'(bits[b]));
        end
        while (first == 0 && k < 400) begin
            @(negedge clk);
            k++;
            if (e ? trdy_e : trdy_n) first = k;
        end
        chk(e ? "tx_e ready latency" : "tx_n ready latency", 32'(first), 32'(nb * BIT_CLK + 1));
        chk(e ? "tx_e busy after frame" : "tx_n busy after frame", 32'(e ? busy_e : busy_n), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        cyc(3);
        chk("reset tx_o", 32'(tx_n), 32'd1);
        chk("reset tx_ready", 32'(trdy_n), 32'd1);
        chk("reset tx_busy", 32'(busy_n), 32'd0);
        chk("reset rx_valid", 32'(val_n), 32'd0);
        chk("reset rx_data", 32'(rxd_n), 32'd0);
        chk("reset errors", 32'({fe_n, pe_n, ovr_n}), 32'd0);
        reset = 1'b1;
        cyc(5);

        tx_frame(1'b0, 8'hA5, {1'b1, 8'hA5, 1'b0}, 10);

        cyc(2);
        loop = 1'b1;
        q_e.push_back('{8'h3C, 1'b0, 1'b0});
        tx_frame(1'b1, 8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        wait_drain(1'b1);
        loop = 1'b0;

        cyc(5);
        sel_e = 1'b1;
        q_e.push_back('{8'h01, 1'b0, 1'b1});
        drive_frame({1'b1, 1'b0, 8'h01, 1'b0}, 11);
        cyc(8);
        wait_drain(1'b1);
        sel_e = 1'b0;

        cyc(5);
        q_n.push_back('{8'h55, 1'b1, 1'b0});
        drive_frame({1'b0, 8'h55, 1'b0}, 10);
        cyc(40);
        rx_drv = 1'b1;
        cyc(20);
        wait_drain(1'b0);
        q_n.push_back('{8'hC3, 1'b0, 1'b0});
        drive_frame({1'b1, 8'hC3, 1'b0}, 10);
        cyc(8);
        wait_drain(1'b0);

        chk("no overrun before fill", 32'(ovr_cnt), 32'd0);
        rdy_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            drive_frame({1'b1, d, 1'b0}, 10);
            cyc(4);
        end
        chk("overrun pulses", 32'(ovr_cnt), 32'd1);
        chk("rx_valid when full", 32'(val_n), 32'd1);
        for (int i = 0; i < 4; i++) q_n.push_back('{8'h11 + 8'(i), 1'b0, 1'b0});
        rdy_n = 1'b1;
        wait_drain(1'b0);
        cyc(2);
        chk("rx_valid after drain", 32'(val_n), 32'd0);

        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(40);
        chk("false start no word", 32'(val_n), 32'd0);

        rdy_n = 1'b0;
        drive_frame({1'b1, 8'h77, 1'b0}, 10);
        cyc(8);
        chk("word held before reset", 32'(val_n), 32'd1);
        txd_n = 8'h00;
        txv_n = 1'b1;
        cyc(1);
        txv_n = 1'b0;
        cyc(50);
        chk("tx mid-frame low", 32'(tx_n), 32'd0);
        chk("tx mid-frame busy", 32'(busy_n), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async reset tx_o", 32'(tx_n), 32'd1);
        chk("async reset tx_ready", 32'(trdy_n), 32'd1);
        chk("async reset rx_valid", 32'(val_n), 32'd0);
        cyc(3);
        reset = 1'b1;
        cyc(3);
        chk("post-reset rx_valid", 32'(val_n), 32'd0);
        chk("post-reset rx_data", 32'(rxd_n), 32'd0);
        chk("post-reset tx_o", 32'(tx_n), 32'd1);
        rdy_n = 1'b1;
        cyc(5);
        chk("rx_n queue empty", 32'(q_n.size()), 32'd0);
        chk("rx_e queue empty", 32'(q_e.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
